ccip_c0_rd_arbiter: RTL and testbench
=====================================

Name: ccip_c0_rd_arbiter

Overview:
Shares the CCI-P c0 Tx read-request channel between N_REQ internal requesters in the NLB-style AFU. Round-robin arbitration is gated by c0TxAlmFull and per-requester outstanding credits. Each request is tagged in mdata with the requester ID. Rx c0 read responses are steered back to the owning requester. The block sits between AFU engines and the registered CCI-P Tx/Rx ports, in the pClk domain.

Parameters:
N_REQ, 4, number of requesters (2..8)
ADDR_W, 42, CCI-P cache-line address width
TAG_W, 8, requester-private tag width; TAG_W + clog2(N_REQ) must be ≤ 16
MAX_OUT, 64, maximum outstanding reads per requester (power of 2)

Ports:
pClk  in  1  CCI-P primary clock; only clock
SoftReset_n  in  1  synchronous, active-low reset
req_valid  in  N_REQ  per-requester read request valid
req_addr  in  N_REQ*ADDR_W  per-requester line address, requester i at slice i
req_tag  in  N_REQ*TAG_W  per-requester tag
req_ready  out  N_REQ  one-hot grant; a request is accepted when req_valid[i] & req_ready[i]
c0TxAlmFull  in  1  CCI-P c0 Tx almost-full
tx_c0_valid  out  1  registered c0 read request valid
tx_c0_addr  out  ADDR_W  registered request address
tx_c0_mdata  out  16  {zeros, id[clog2(N_REQ)-1:0], tag[TAG_W-1:0]}
rx_c0_rspValid  in  1  c0 read response valid; already registered by the parent
rx_c0_mdata  in  16  response mdata
rx_c0_data  in  512  response cache line
rsp_valid  out  N_REQ  one-hot routed response valid
rsp_tag  out  TAG_W  tag of the routed response
rsp_data  out  512  data of the routed response
idle  out  1  no request in flight and all outstanding counters are zero
err_sticky  out  2  bit0 unknown-ID response; bit1 counter-underflow response

Behaviour:
- Reset (SoftReset_n=0 at a pClk edge): all outputs 0; round-robin pointer = 0; all counters = 0; err_sticky = 0. idle = 1 from the first cycle after reset.
- Eligibility: requester i is eligible when req_valid[i] & (cnt[i] < MAX_OUT) & !c0TxAlmFull, using the same-cycle c0TxAlmFull value.
- Grant: combinational one-hot. Search starts at index ptr and wraps modulo N_REQ. req_ready is 0 whenever c0TxAlmFull = 1 or SoftReset_n = 0.
- On accept: ptr <= (granted+1) mod N_REQ; the next cycle tx_c0_valid = 1 with the captured addr and mdata. Request latency is 1 cycle. At most 1 request per cycle. tx_c0_valid = 0 in cycles with no accept.
- Counters: cnt[i] increments on accept by i and decrements on a valid routed response to i. A simultaneous accept and response for the same i leaves cnt[i] unchanged. A counter at MAX_OUT blocks only that requester.
- Response path, 1-cycle latency: id = rx_c0_mdata[TAG_W +: clog2(N_REQ)].
  - id < N_REQ: rsp_valid[id] = 1, rsp_tag = rx_c0_mdata[TAG_W-1:0], rsp_data = rx_c0_data.
  - id ≥ N_REQ (non-power-of-2 N_REQ) or mdata[15:TAG_W+clog2(N_REQ)] ≠ 0: response dropped, err_sticky[0] set.
  - Response arriving with cnt[id] = 0 (e.g. after reset mid-operation): response still routed, cnt held at 0, err_sticky[1] set.
- Responses are never backpressured; requesters must always sink them.
- err_sticky clears only on reset.
- idle = !tx_c0_valid & (all cnt = 0), registered.

Decomposition:
- Shared package ccip_arb_pkg: MDATA_W = 16; CCIP_CL_W = 512; function to pack/unpack mdata {id, tag}; err bit index constants.
- One sub-module, rr_arbiter_onehot (N-wide round-robin with pointer input and one-hot grant output), reusable for the c1 write arbiter.
- Counters and response demux stay inline.

Test Plan:
- All 4 requesters valid continuously, MAX_OUT=64, AlmFull=0 -> tx_c0_mdata ID sequence 0,1,2,3,0…; one tx_c0_valid per cycle; each req_ready pulses every 4th cycle.
- Requester 2 issues 64 reads with no responses -> req_ready[2] stays 0 from the 65th attempt; requesters 0, 1, 3 continue to be served. After one response to ID 2, exactly one more grant goes to 2.
- c0TxAlmFull asserted for 10 cycles mid-stream -> req_ready = 0 in those exact cycles; zero tx_c0_valid one cycle later; round-robin order resumes from the saved pointer.
- Response mdata = 0x0105 (ID 1, tag 0x05) -> next cycle rsp_valid = 4'b0010, rsp_tag = 0x05, rsp_data matches. A response with ID 1 arriving in the same cycle as a grant to 1 -> cnt[1] unchanged.
- Response mdata = 0x8000 -> no rsp_valid, err_sticky[0] = 1. Issue 3 reads, assert reset, then deliver 3 responses -> responses routed, err_sticky[1] = 1, counters stay 0, idle = 1.
- Reset asserted while tx_c0_valid = 1 -> next cycle all outputs 0 and ptr = 0; the first grant after reset goes to the lowest valid requester.

Source files
------------

// File: rtl/ccip_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ccip_arb_pkg
// Brief    : Shared CCI-P arbiter widths, error bit indices and mdata helpers
// Revision : 1.0  initial release
// ============================================================================
package ccip_arb_pkg;

  localparam int MDATA_W        = 16;
  localparam int CCIP_CL_W      = 512;
  localparam int ERR_UNKNOWN_ID = 0;
  localparam int ERR_UNDERFLOW  = 1;

  // mdata layout is {zeros, id, tag}; the caller keeps id and tag within their fields
  function automatic logic [MDATA_W-1:0] pack_mdata(input int unsigned id,
                                                    input int unsigned tag,
                                                    input int unsigned tag_w);
    return (MDATA_W'(id) << tag_w) | MDATA_W'(tag);
  endfunction

  function automatic int unsigned mdata_id(input logic [MDATA_W-1:0] mdata,
                                           input int unsigned tag_w,
                                           input int unsigned id_w);
    logic [MDATA_W-1:0] mask;
    mask = (MDATA_W'(1) << id_w) - MDATA_W'(1);
    return 32'((mdata >> tag_w) & mask);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter_onehot.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter_onehot
// Brief    : N-wide round-robin search from an external pointer, one-hot grant
// Revision : 1.0  initial release
// ============================================================================
module rr_arbiter_onehot #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_any
);

  always_comb begin
    int unsigned idx;
    idx       = 0;
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = (32'(ptr) + 32'(k)) % 32'(N);
      if (!grant_any && req[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = IDX_W'(idx);
        grant_any  = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/ccip_c0_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ccip_c0_rd_arbiter
// Brief    : Round-robin sharing of the CCI-P c0 read channel with ID-tagged
//            mdata, per-requester credits and response steering
// Revision : 1.0  initial release
// ============================================================================
module ccip_c0_rd_arbiter
  import ccip_arb_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int ADDR_W  = 42,
  parameter int TAG_W   = 8,
  parameter int MAX_OUT = 64
) (
  input  logic                    pClk,
  input  logic                    SoftReset_n,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  input  logic [N_REQ*TAG_W-1:0]  req_tag,
  output logic [N_REQ-1:0]        req_ready,
  input  logic                    c0TxAlmFull,
  output logic                    tx_c0_valid,
  output logic [ADDR_W-1:0]       tx_c0_addr,
  output logic [MDATA_W-1:0]      tx_c0_mdata,
  input  logic                    rx_c0_rspValid,
  input  logic [MDATA_W-1:0]      rx_c0_mdata,
  input  logic [CCIP_CL_W-1:0]    rx_c0_data,
  output logic [N_REQ-1:0]        rsp_valid,
  output logic [TAG_W-1:0]        rsp_tag,
  output logic [CCIP_CL_W-1:0]    rsp_data,
  output logic                    idle,
  output logic [1:0]              err_sticky
);

  localparam int ID_W  = $clog2(N_REQ);
  localparam int CNT_W = $clog2(MAX_OUT) + 1;

  logic [ID_W-1:0]  ptr;
  logic [CNT_W-1:0] cnt     [N_REQ];
  logic [CNT_W-1:0] cnt_nxt [N_REQ];
  logic [N_REQ-1:0] eligible;
  logic [N_REQ-1:0] grant;
  logic [ID_W-1:0]  grant_idx;
  logic             grant_any;
  logic             accept;
  logic [ID_W-1:0]  ptr_nxt;

  int unsigned      rx_id;
  logic             rx_known;
  logic             rx_route;
  logic [N_REQ-1:0] rx_onehot;
  logic [N_REQ-1:0] underflow;
  logic             cnt_all_zero_nxt;

  always_comb begin
    for (int i = 0; i < N_REQ; i++)
      eligible[i] = req_valid[i] && (cnt[i] < CNT_W'(MAX_OUT)) && !c0TxAlmFull;
  end

  rr_arbiter_onehot #(
    .N     (N_REQ),
    .IDX_W (ID_W)
  ) u_rr (
    .req       (eligible),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  // grant only ever lands on an eligible (hence valid) requester, so it is the handshake
  assign req_ready = SoftReset_n ? grant : '0;
  assign accept    = SoftReset_n && grant_any;
  assign ptr_nxt   = (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;

  // Responses with stray high mdata bits or an out-of-range ID are dropped
  always_comb begin
    rx_id     = mdata_id(rx_c0_mdata, TAG_W, ID_W);
    rx_known  = ((rx_c0_mdata >> (TAG_W + ID_W)) == '0) && (rx_id < N_REQ);
    rx_route  = rx_c0_rspValid && rx_known;
    rx_onehot = '0;
    for (int i = 0; i < N_REQ; i++)
      rx_onehot[i] = rx_route && (rx_id == i);
  end

  always_comb begin
    cnt_all_zero_nxt = 1'b1;
    for (int i = 0; i < N_REQ; i++) begin
      underflow[i] = rx_onehot[i] && (cnt[i] == '0);
      cnt_nxt[i]   = cnt[i];
      if (accept && grant[i] && !rx_onehot[i])
        cnt_nxt[i] = cnt[i] + 1'b1;
      else if (!(accept && grant[i]) && rx_onehot[i] && (cnt[i] != '0))
        cnt_nxt[i] = cnt[i] - 1'b1;
      if (cnt_nxt[i] != '0)
        cnt_all_zero_nxt = 1'b0;
    end
  end

  always_ff @(posedge pClk) begin
    if (!SoftReset_n) begin
      ptr         <= '0;
      tx_c0_valid <= 1'b0;
      tx_c0_addr  <= '0;
      tx_c0_mdata <= '0;
      rsp_valid   <= '0;
      rsp_tag     <= '0;
      rsp_data    <= '0;
      idle        <= 1'b1;
      err_sticky  <= '0;
      for (int i = 0; i < N_REQ; i++)
        cnt[i] <= '0;
    end else begin
      tx_c0_valid <= accept;
      if (accept) begin
        ptr         <= ptr_nxt;
        tx_c0_addr  <= req_addr[grant_idx*ADDR_W +: ADDR_W];
        tx_c0_mdata <= pack_mdata(32'(grant_idx),
                                  32'(req_tag[grant_idx*TAG_W +: TAG_W]), TAG_W);
      end
      rsp_valid <= rx_onehot;
      if (rx_route) begin
        rsp_tag  <= rx_c0_mdata[TAG_W-1:0];
        rsp_data <= rx_c0_data;
      end
      for (int i = 0; i < N_REQ; i++)
        cnt[i] <= cnt_nxt[i];
      if (rx_c0_rspValid && !rx_known)
        err_sticky[ERR_UNKNOWN_ID] <= 1'b1;
      if (|underflow)
        err_sticky[ERR_UNDERFLOW] <= 1'b1;
      idle <= !accept && cnt_all_zero_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ccip_c0_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ccip_c0_rd_arbiter
// Brief    : Directed self-checking bench for the c0 read arbiter
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_ccip_c0_rd_arbiter;

  localparam int N_REQ   = 4;
  localparam int ADDR_W  = 42;
  localparam int TAG_W   = 8;
  localparam int MAX_OUT = 64;

  logic                    clk = 1'b0;
  logic                    SoftReset_n;
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [N_REQ*TAG_W-1:0]  req_tag;
  logic [N_REQ-1:0]        req_ready;
  logic                    c0TxAlmFull;
  logic                    tx_c0_valid;
  logic [ADDR_W-1:0]       tx_c0_addr;
  logic [15:0]             tx_c0_mdata;
  logic                    rx_c0_rspValid;
  logic [15:0]             rx_c0_mdata;
  logic [511:0]            rx_c0_data;
  logic [N_REQ-1:0]        rsp_valid;
  logic [TAG_W-1:0]        rsp_tag;
  logic [511:0]            rsp_data;
  logic                    idle;
  logic [1:0]              err_sticky;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ccip_c0_rd_arbiter #(
    .N_REQ(N_REQ), .ADDR_W(ADDR_W), .TAG_W(TAG_W), .MAX_OUT(MAX_OUT)
  ) dut (
    .pClk(clk), .SoftReset_n(SoftReset_n),
    .req_valid(req_valid), .req_addr(req_addr), .req_tag(req_tag), .req_ready(req_ready),
    .c0TxAlmFull(c0TxAlmFull),
    .tx_c0_valid(tx_c0_valid), .tx_c0_addr(tx_c0_addr), .tx_c0_mdata(tx_c0_mdata),
    .rx_c0_rspValid(rx_c0_rspValid), .rx_c0_mdata(rx_c0_mdata), .rx_c0_data(rx_c0_data),
    .rsp_valid(rsp_valid), .rsp_tag(rsp_tag), .rsp_data(rsp_data),
    .idle(idle), .err_sticky(err_sticky)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  // Requester i presents address 0x100+i and tag 0x10+i
  task automatic grant_step(input int id);
    settle();
    chk("ready", 64'(req_ready), 64'(1 << id));
    tick();
    chk("tx_valid", 64'(tx_c0_valid), 64'd1);
    chk("tx_mdata", 64'(tx_c0_mdata), 64'((id << 8) | (16 + id)));
    chk("tx_addr", 64'(tx_c0_addr), 64'(256 + id));
  endtask

  task automatic send_rsp(input logic [15:0] m, input logic [511:0] d);
    rx_c0_rspValid = 1'b1;
    rx_c0_mdata    = m;
    rx_c0_data     = d;
    tick();
    rx_c0_rspValid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [511:0] d;
    d = '0;
    d[63:0]    = 64'hDEAD_BEEF_0123_4567;
    d[511:448] = 64'hCAFE_F00D_8899_AABB;

    SoftReset_n    = 1'b0;
    c0TxAlmFull    = 1'b0;
    rx_c0_rspValid = 1'b0;
    rx_c0_mdata    = '0;
    rx_c0_data     = '0;
    req_valid      = 4'hF;
    for (int i = 0; i < N_REQ; i++) begin
      req_addr[i*ADDR_W +: ADDR_W] = ADDR_W'(256 + i);
      req_tag[i*TAG_W +: TAG_W]    = TAG_W'(16 + i);
    end

    // Reset state
    settle();
    chk("rst_ready_gate", 64'(req_ready), 64'd0);
    tick();
    tick();
    chk("rst_tx_valid", 64'(tx_c0_valid), 64'd0);
    chk("rst_idle", 64'(idle), 64'd1);
    chk("rst_err", 64'(err_sticky), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    SoftReset_n = 1'b1;

    // Round robin with all requesters valid, then AlmFull mid-stream
    for (int k = 0; k < 10; k++) grant_step(k % 4);
    c0TxAlmFull = 1'b1;
    for (int k = 0; k < 10; k++) begin
      settle();
      chk("almfull_ready", 64'(req_ready), 64'd0);
      tick();
      chk("almfull_tx", 64'(tx_c0_valid), 64'd0);
    end
    c0TxAlmFull = 1'b0;
    grant_step(2);
    grant_step(3);
    req_valid = '0;
    settle();
    chk("no_req_ready", 64'(req_ready), 64'd0);
    tick();
    chk("no_req_tx", 64'(tx_c0_valid), 64'd0);
    chk("busy_idle", 64'(idle), 64'd0);

    // Routed response; outstanding: r0=3 r1=3 r2=3 r3=3
    send_rsp(16'h0105, d);
    chk("rsp_valid", 64'(rsp_valid), 64'h2);
    chk("rsp_tag", 64'(rsp_tag), 64'h05);
    chk("rsp_data_lo", rsp_data[63:0], 64'hDEAD_BEEF_0123_4567);
    chk("rsp_data_hi", rsp_data[511:448], 64'hCAFE_F00D_8899_AABB);

    // Grant and response to requester 1 in the same cycle: r1 stays 2
    req_valid      = 4'b0010;
    rx_c0_rspValid = 1'b1;
    rx_c0_mdata    = 16'h0107;
    settle();
    chk("simul_ready", 64'(req_ready), 64'h2);
    tick();
    rx_c0_rspValid = 1'b0;
    req_valid      = '0;
    chk("simul_tx", 64'(tx_c0_valid), 64'd1);
    chk("simul_rsp", 64'(rsp_valid), 64'h2);
    chk("simul_rsp_tag", 64'(rsp_tag), 64'h07);

    // Drain: idle must appear exactly after the last outstanding response
    for (int k = 0; k < 3; k++) send_rsp(16'h0000, d);
    for (int k = 0; k < 3; k++) send_rsp(16'h0200, d);
    for (int k = 0; k < 3; k++) send_rsp(16'h0300, d);
    send_rsp(16'h0100, d);
    chk("drain_not_idle", 64'(idle), 64'd0);
    send_rsp(16'h0100, d);
    chk("drain_idle", 64'(idle), 64'd1);
    chk("drain_err", 64'(err_sticky), 64'd0);

    // Credit limit on requester 2 (pointer is at 2 after the grant to 1)
    req_valid = 4'b0100;
    for (int k = 0; k < MAX_OUT; k++) grant_step(2);
    settle();
    chk("max_block", 64'(req_ready), 64'd0);
    tick();
    chk("max_block_tx", 64'(tx_c0_valid), 64'd0);
    req_valid = 4'hF;
    grant_step(3);
    grant_step(0);
    grant_step(1);
    grant_step(3);
    req_valid = '0;
    send_rsp(16'h0200, d);
    req_valid = 4'b0100;
    grant_step(2);
    settle();
    chk("max_reblock", 64'(req_ready), 64'd0);
    req_valid = '0;
    tick();

    // Unknown-ID response
    send_rsp(16'h8000, d);
    chk("unk_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("unk_err", 64'(err_sticky), 64'h1);

    // Reset while a request is on the Tx port, then late responses
    req_valid = 4'b0001;
    for (int k = 0; k < 3; k++) grant_step(0);
    SoftReset_n = 1'b0;
    settle();
    chk("rst2_ready", 64'(req_ready), 64'd0);
    tick();
    chk("rst2_tx", 64'(tx_c0_valid), 64'd0);
    chk("rst2_mdata", 64'(tx_c0_mdata), 64'd0);
    chk("rst2_addr", 64'(tx_c0_addr), 64'd0);
    chk("rst2_err", 64'(err_sticky), 64'd0);
    chk("rst2_idle", 64'(idle), 64'd1);
    SoftReset_n = 1'b1;
    req_valid   = '0;
    for (int k = 1; k <= 3; k++) begin
      send_rsp(16'(k), d);
      chk("late_rsp_valid", 64'(rsp_valid), 64'h1);
      chk("late_rsp_tag", 64'(rsp_tag), 64'(k));
    end
    chk("late_err", 64'(err_sticky), 64'h2);
    chk("late_idle", 64'(idle), 64'd1);

    // First grant after reset goes to the lowest valid requester
    req_valid = 4'b1010;
    settle();
    chk("post_rst_ready", 64'(req_ready), 64'h2);
    tick();
    chk("post_rst_mdata", 64'(tx_c0_mdata), 64'h0111);
    req_valid = '0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
